// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM with byte-lane stores and fixed-latency extended loads.
// Optional DMEM_MISALIGN_CHECK_EN rejects misaligned H/HU/W accesses instead of ignoring low bits.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_flag,
    input  logic        store_flag,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  LAST = 3'(RD_LAT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt;
    logic [31:0] hold;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          in_range;
    logic          misaligned;
    logic          addr_ok;
    logic          store_req, load_req;
    logic          store_ok, load_ok;
    logic          reject;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_ext;
    logic [31:0]   load_data;

    assign idx      = addr[2 +: AW];
    assign in_range = (addr[31:2] < 30'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign addr_ok = in_range && !misaligned;

    // A simultaneous store wins; the load half of the request is dropped silently.
    assign store_req = (state == IDLE) && store_flag;
    assign load_req  = (state == IDLE) && load_flag && !store_flag;

    assign store_ok = store_req && (funct3 inside {3'b000, 3'b001, 3'b010}) && addr_ok;
    assign load_ok  = load_req && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && addr_ok;
    assign reject   = (store_req && !store_ok) || (load_req && !load_ok);

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_ext = rd_word;
        case (funct3[1:0])
            2'b00:   load_ext = funct3[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = funct3[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_ext = rd_word;
        endcase
    end

    // Rejected loads still run the latency sequence, returning zero.
    assign load_data = load_ok ? load_ext : '0;

    always_ff @(posedge clk) begin
        if (store_ok) begin
            case (funct3[1:0])
                2'b00:   mem[idx][{addr[1:0], 3'b000} +: 8] <= wdata[7:0];
                2'b01:   mem[idx][{addr[1], 4'b0000} +: 16] <= wdata[15:0];
                default: mem[idx] <= wdata;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_req && (RD_LAT > 1)) state_next = WAIT;
            WAIT:    if (cnt == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            hold     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= reject;
            if (load_req) begin
                if (RD_LAT == 1) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= load_data;
                end else begin
                    hold <= load_data;
                    cnt  <= 3'd1;
                end
            end else if (state == WAIT) begin
                if (cnt == LAST) begin
                    cnt      <= '0;
                    rvalid_q <= 1'b1;
                    rdata_q  <= hold;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, RD_LAT=2).
// Follows DMEM_MISALIGN_CHECK_EN to pick the expected misaligned-access behaviour.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_flag = 1'b0;
    logic        store_flag = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .load_flag(load_flag), .store_flag(store_flag),
        .addr(addr), .wdata(wdata), .funct3(funct3),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        store_flag = 1'b1; addr = a; wdata = d; funct3 = f3;
        cycle();
        store_flag = 1'b0;
    endtask

    // Issues a load and waits (bounded) for rvalid; lat counts edges from acceptance.
    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] data,
                           output int lat, output logic err_seen, output logic busy_first);
        load_flag = 1'b1; addr = a; funct3 = f3;
        cycle();
        load_flag = 1'b0;
        lat = 1; err_seen = err; busy_first = busy;
        while (!rvalid && lat < 8) begin
            cycle();
            lat++;
        end
        data = rdata;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        cycle(); cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_word();
        logic [31:0] d; int lat; logic e; logic b;
        do_store(32'h10, 32'h8000_00F0, 3'b010);
        checks++; if ({err, busy, rvalid} !== 3'b000) begin errors++; $display("FAIL sw_flags got %b exp 000", {err, busy, rvalid}); end
        do_load(32'h10, 3'b010, d, lat, e, b);
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL lw_busy got %b exp 1", b); end
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
        checks++; if (d !== 32'h8000_00F0) begin errors++; $display("FAIL lw_data got %h exp 800000f0", d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lw_busy_at_rvalid got %b exp 0", busy); end
        cycle();
        checks++; if ({rvalid, rdata} !== 33'h0) begin errors++; $display("FAIL lw_after got %b/%h exp 0/00000000", rvalid, rdata); end
    endtask

    task automatic test_extend();
        logic [31:0] ta [4] = '{32'h10, 32'h10, 32'h12, 32'h12};
        logic [2:0]  tf [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] te [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000};
        logic [31:0] d; int lat; logic e; logic b;
        for (int unsigned i = 0; i < 4; i++) begin
            do_load(ta[i], tf[i], d, lat, e, b);
            checks++; if (d !== te[i] || lat != 2) begin errors++; $display("FAIL ext_%0d got %h lat %0d exp %h lat 2", i, d, lat, te[i]); end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; int lat; logic e; logic b;
        do_load(32'h10, 3'b000, d, lat, e, b);
        do_load(32'h12, 3'b101, d, lat, e, b);
        checks++; if (d !== 32'h0000_8000 || lat != 2) begin errors++; $display("FAIL b2b got %h lat %0d exp 00008000 lat 2", d, lat); end
        cycle();
    endtask

    task automatic test_byte_store();
        logic [31:0] d; int lat; logic e; logic b;
        do_store(32'h20, 32'h1111_1111, 3'b010);
        do_store(32'h21, 32'hFFFF_FFAB, 3'b000);
        do_load(32'h20, 3'b010, d, lat, e, b);
        checks++; if (d !== 32'h1111_AB11) begin errors++; $display("FAIL sb_lane got %h exp 1111ab11", d); end
        cycle();
        do_store(32'h22, 32'h1234_BEEF, 3'b001);
        do_load(32'h20, 3'b010, d, lat, e, b);
        checks++; if (d !== 32'hBEEF_AB11) begin errors++; $display("FAIL sh_lane got %h exp beefab11", d); end
        cycle();
    endtask

    task automatic test_reject();
        logic [31:0] d; int lat; logic e; logic b;
        do_load(32'h1000, 3'b010, d, lat, e, b);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_load_err got %b exp 1", e); end
        checks++; if (d !== 32'h0 || lat != 2) begin errors++; $display("FAIL oor_load_data got %h lat %0d exp 00000000 lat 2", d, lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b exp 0", err); end
        cycle();
        do_store(32'h20, 32'h0000_0055, 3'b100);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_f3_store_err got %b exp 1", err); end
        do_store(32'h1020, 32'h0000_0055, 3'b010);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_store_err got %b exp 1", err); end
        do_load(32'h20, 3'b010, d, lat, e, b);
        checks++; if (d !== 32'hBEEF_AB11) begin errors++; $display("FAIL rejected_store_kept got %h exp beefab11", d); end
        cycle();
        do_load(32'h20, 3'b011, d, lat, e, b);
        checks++; if (e !== 1'b1 || d !== 32'h0 || lat != 2) begin errors++; $display("FAIL bad_f3_load got err %b %h lat %0d exp err 1 00000000 lat 2", e, d, lat); end
        cycle();
    endtask

    task automatic test_reset_in_wait();
        logic seen = 1'b0;
        load_flag = 1'b1; addr = 32'h10; funct3 = 3'b010;
        cycle();
        load_flag = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_busy_pre got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, rvalid} !== 2'b00) begin errors++; $display("FAIL rstwait_immediate got %b exp 00", {busy, rvalid}); end
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rvalid) seen = 1'b1;
            cycle();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstwait_no_rvalid got %b exp 0", seen); end
    endtask

    task automatic test_both_flags();
        logic [31:0] d; int lat; logic e; logic b;
        load_flag = 1'b1;
        do_store(32'h30, 32'h0000_0005, 3'b010);
        load_flag = 1'b0;
        checks++; if ({busy, err} !== 2'b00) begin errors++; $display("FAIL both_busy_err got %b exp 00", {busy, err}); end
        cycle();
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL both_rvalid got %b exp 0", rvalid); end
        do_load(32'h30, 3'b010, d, lat, e, b);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL both_data got %h exp 00000005", d); end
        cycle();
    endtask

    task automatic test_write_first();
        logic [31:0] d; int lat; logic e; logic b;
        do_store(32'h40, 32'h1234_5678, 3'b010);
        do_load(32'h40, 3'b010, d, lat, e, b);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL write_first got %h exp 12345678", d); end
        cycle();
    endtask

    task automatic test_misalign();
        logic [31:0] d; int lat; logic e; logic b;
        logic        exp_err;
        logic [31:0] exp_w, exp_h;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_err = 1'b1; exp_w = 32'h0; exp_h = 32'h0;
`else
        exp_err = 1'b0; exp_w = 32'h8000_00F0; exp_h = 32'h0000_00F0;
`endif
        do_load(32'h13, 3'b010, d, lat, e, b);
        checks++; if (e !== exp_err || d !== exp_w || lat != 2) begin errors++; $display("FAIL misalign_lw got err %b %h lat %0d exp err %b %h lat 2", e, d, lat, exp_err, exp_w); end
        cycle();
        do_load(32'h11, 3'b001, d, lat, e, b);
        checks++; if (e !== exp_err || d !== exp_h) begin errors++; $display("FAIL misalign_lh got err %b %h exp err %b %h", e, d, exp_err, exp_h); end
        cycle();
    endtask

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_back_to_back();
        test_byte_store();
        test_reject();
        test_both_flags();
        test_write_first();
        test_misalign();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
